// File: rtl/dmem_arb.sv
// Two-master arbiter in front of the data-memory bus. Write and read channels
// arbitrate independently; read data is steered back to the issuing master.
module dmem_arb #(
    parameter int FIXED_PRIO = 0,
    parameter int AW         = 32
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          m0_wready,
    input  logic          m1_wready,
    output logic          m0_wvalid,
    output logic          m1_wvalid,
    input  logic [AW-1:0] m0_waddr,
    input  logic [AW-1:0] m1_waddr,
    input  logic [31:0]   m0_wdata,
    input  logic [31:0]   m1_wdata,
    input  logic [3:0]    m0_wstrb,
    input  logic [3:0]    m1_wstrb,
    input  logic          m0_rready,
    input  logic          m1_rready,
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    input  logic [AW-1:0] m0_raddr,
    input  logic [AW-1:0] m1_raddr,
    output logic          m0_rresp,
    output logic          m1_rresp,
    output logic [31:0]   m0_rdata,
    output logic [31:0]   m1_rdata,
    output logic          s_wready,
    input  logic          s_wvalid,
    output logic [AW-1:0] s_waddr,
    output logic [31:0]   s_wdata,
    output logic [3:0]    s_wstrb,
    output logic          s_rready,
    input  logic          s_rvalid,
    output logic [AW-1:0] s_raddr,
    input  logic          s_rresp,
    input  logic [31:0]   s_rdata
);

    logic w_ptr, w_lock, w_own, w_gnt, w_act;
    logic r_ptr, r_lock, r_own, r_gnt, r_act;
    logic r_sel, r_pend;

    // A locked channel keeps its owner until the memory accepts, so a
    // presented request is never withdrawn from under the memory.
    always_comb begin
        w_gnt = 1'b0;
        w_act = 1'b0;
        if (w_lock) begin
            w_gnt = w_own;
            w_act = w_own ? m1_wready : m0_wready;
        end else if (m0_wready && m1_wready) begin
            w_gnt = (FIXED_PRIO != 0) ? 1'b0 : w_ptr;
            w_act = 1'b1;
        end else if (m1_wready) begin
            w_gnt = 1'b1;
            w_act = 1'b1;
        end else if (m0_wready) begin
            w_act = 1'b1;
        end
    end

    always_comb begin
        r_gnt = 1'b0;
        r_act = 1'b0;
        if (r_lock) begin
            r_gnt = r_own;
            r_act = r_own ? m1_rready : m0_rready;
        end else if (m0_rready && m1_rready) begin
            r_gnt = (FIXED_PRIO != 0) ? 1'b0 : r_ptr;
            r_act = 1'b1;
        end else if (m1_rready) begin
            r_gnt = 1'b1;
            r_act = 1'b1;
        end else if (m0_rready) begin
            r_act = 1'b1;
        end
    end

    assign s_wready  = w_act;
    assign s_waddr   = w_gnt ? m1_waddr : m0_waddr;
    assign s_wdata   = w_gnt ? m1_wdata : m0_wdata;
    assign s_wstrb   = w_gnt ? m1_wstrb : m0_wstrb;
    assign m0_wvalid = w_act && !w_gnt && s_wvalid;
    assign m1_wvalid = w_act &&  w_gnt && s_wvalid;

    assign s_rready  = r_act;
    assign s_raddr   = r_gnt ? m1_raddr : m0_raddr;
    assign m0_rvalid = r_act && !r_gnt && s_rvalid;
    assign m1_rvalid = r_act &&  r_gnt && s_rvalid;

    // Data phase follows the accept by one cycle and goes only to the issuer.
    assign m0_rdata  = (r_pend && !r_sel) ? s_rdata : 32'd0;
    assign m1_rdata  = (r_pend &&  r_sel) ? s_rdata : 32'd0;
    assign m0_rresp  = r_pend && !r_sel && s_rresp;
    assign m1_rresp  = r_pend &&  r_sel && s_rresp;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            w_ptr  <= 1'b0;
            w_lock <= 1'b0;
            w_own  <= 1'b0;
        end else if (w_act) begin
            if (s_wvalid) begin
                w_lock <= 1'b0;
                w_ptr  <= ~w_gnt;
            end else begin
                w_lock <= 1'b1;
                w_own  <= w_gnt;
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_ptr  <= 1'b0;
            r_lock <= 1'b0;
            r_own  <= 1'b0;
            r_sel  <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            r_pend <= r_act && s_rvalid;
            if (r_act) begin
                if (s_rvalid) begin
                    r_lock <= 1'b0;
                    r_ptr  <= ~r_gnt;
                    r_sel  <= r_gnt;
                end else begin
                    r_lock <= 1'b1;
                    r_own  <= r_gnt;
                end
            end
        end
    end

endmodule
